// File: rtl/sram_like_to_axi_pkg.sv
// sram_like_to_axi_pkg: shared types and constants for the sram-like to AXI bridge.
//   - state_e  : bridge FSM encoding
//   - xact_t   : request latched at grant time
//   - AXI tie-off constants (single-beat INCR, no lock/cache/prot)
//   - size codes and default AXI IDs per upstream port
package sram_like_to_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW   = 3'd3,
    S_B    = 3'd4
  } state_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        owner;  // 1 = data port, 0 = inst port
  } xact_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_LOCK_NONE  = 2'd0;
  localparam logic [3:0] AXI_CACHE_NONE = 4'd0;
  localparam logic [2:0] AXI_PROT_NONE  = 3'd0;

  localparam logic [3:0] INST_ID_DEF = 4'd0;
  localparam logic [3:0] DATA_ID_DEF = 4'd1;

endpackage

// File: rtl/sram_like_to_axi_wstrb_gen.sv
// axi_wstrb_gen: combinational decoder from transfer size + address low bits to
// AXI write strobes. Size 3 is treated as a full word.
//   size_i    : 0=byte, 1=half, 2/3=word
//   addr_lo_i : address bits [1:0]
//   wstrb_o   : byte-lane strobes
module axi_wstrb_gen
  import sram_like_to_axi_pkg::*;
(
  input  logic [1:0] size_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] wstrb_o
);

  always_comb begin
    wstrb_o = 4'b1111;
    case (size_i)
      SIZE_BYTE: wstrb_o = 4'b0001 << addr_lo_i;
      SIZE_HALF: wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      default:   wstrb_o = 4'b1111;
    endcase
  end

endmodule

// File: rtl/sram_like_to_axi.sv
// sram_like_to_axi: bridges the inst and data sram-like masters onto one AXI
// master, one outstanding transaction at a time, data port has priority.
//   clk, rst             : clock, asynchronous active-low reset
//   inst_* / data_*      : sram-like request (req/wr/size/addr/wdata) and
//                          response (addr_ok/data_ok/rdata) per port
//   ar*/r*/aw*/w*/b*     : AXI master channels, single-beat only
// Optional: define AXI_BRIDGE_PERF_CNT_EN to add perf_rd_cnt, perf_wr_cnt and
// perf_wait_cnt (completed reads, completed writes, non-idle cycles).
module sram_like_to_axi
  import sram_like_to_axi_pkg::*;
#(
  parameter logic [3:0] INST_ID = INST_ID_DEF,
  parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
  input  logic        clk,
  input  logic        rst,
  // inst port
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  // data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
`ifdef AXI_BRIDGE_PERF_CNT_EN
  ,
  output logic [31:0] perf_rd_cnt,
  output logic [31:0] perf_wr_cnt,
  output logic [31:0] perf_wait_cnt
`endif
);

  state_e state_q, state_d;
  xact_t  xact_q, xact_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   aw_hs, w_hs;
  logic [3:0] own_id;

  // IDs, responses and rlast carry nothing for a single-outstanding bridge.
  logic unused_ok;
  assign unused_ok = ^{rid, rresp, rlast, bid, bresp};

  assign own_id = xact_q.owner ? DATA_ID : INST_ID;

  // Channel valids/readies are pure decodes of registered state, so reset
  // clears them immediately.
  assign arvalid = (state_q == S_AR);
  assign rready  = (state_q == S_R);
  assign awvalid = (state_q == S_AW) && !aw_done_q;
  assign wvalid  = (state_q == S_AW) && !w_done_q;
  assign bready  = (state_q == S_B);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  assign arid    = own_id;
  assign araddr  = xact_q.addr;
  assign arsize  = {1'b0, xact_q.size};
  assign awid    = own_id;
  assign awaddr  = xact_q.addr;
  assign awsize  = {1'b0, xact_q.size};
  assign wid     = own_id;
  assign wdata   = xact_q.wdata;
  assign wlast   = 1'b1;

  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = AXI_LOCK_NONE;
  assign arcache = AXI_CACHE_NONE;
  assign arprot  = AXI_PROT_NONE;
  assign awlen   = AXI_LEN_SINGLE;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = AXI_LOCK_NONE;
  assign awcache = AXI_CACHE_NONE;
  assign awprot  = AXI_PROT_NONE;

  // rdata is only meaningful while the owner's data_ok is high.
  assign inst_rdata = rdata;
  assign data_rdata = rdata;

  axi_wstrb_gen u_wstrb (
    .size_i    (xact_q.size),
    .addr_lo_i (xact_q.addr[1:0]),
    .wstrb_o   (wstrb)
  );

  always_comb begin
    state_d      = state_q;
    xact_d       = xact_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (state_q)
      S_IDLE: begin
        // rst gate keeps addr_ok low while reset is asserted
        if (data_req && rst) begin
          data_addr_ok = 1'b1;
          xact_d       = '{wr: data_wr, size: data_size, addr: data_addr,
                           wdata: data_wdata, owner: 1'b1};
          state_d      = data_wr ? S_AW : S_AR;
        end else if (inst_req && rst) begin
          inst_addr_ok = 1'b1;
          xact_d       = '{wr: inst_wr, size: inst_size, addr: inst_addr,
                           wdata: inst_wdata, owner: 1'b0};
          state_d      = inst_wr ? S_AW : S_AR;
        end
      end
      S_AR: if (arready) state_d = S_R;
      S_R: begin
        if (rvalid) begin
          data_data_ok = xact_q.owner;
          inst_data_ok = !xact_q.owner;
          state_d      = S_IDLE;
        end
      end
      S_AW: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        // Readies may land in either order; leave once both beats are out.
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_B;
        end
      end
      S_B: begin
        if (bvalid) begin
          data_data_ok = xact_q.owner;
          inst_data_ok = !xact_q.owner;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      xact_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      xact_q    <= xact_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

`ifdef AXI_BRIDGE_PERF_CNT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q, wait_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      if (state_q == S_R && rvalid) rd_cnt_q   <= rd_cnt_q + 32'd1;
      if (state_q == S_B && bvalid) wr_cnt_q   <= wr_cnt_q + 32'd1;
      if (state_q != S_IDLE)        wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end

  assign perf_rd_cnt   = rd_cnt_q;
  assign perf_wr_cnt   = wr_cnt_q;
  assign perf_wait_cnt = wait_cnt_q;
`endif

endmodule

// File: tb/tb_sram_like_to_axi.sv
// Directed bench for sram_like_to_axi; the test acts as the AXI slave by hand.
module tb_sram_like_to_axi;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
`ifdef AXI_BRIDGE_PERF_CNT_EN
  logic [31:0] perf_rd_cnt, perf_wr_cnt, perf_wait_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_like_to_axi dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef AXI_BRIDGE_PERF_CNT_EN
    ,
    .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt),
    .perf_wait_cnt(perf_wait_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 0; data_wdata = 0;
    arready = 0; awready = 0; wready = 0;
    rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    bid = 0; bresp = 0; bvalid = 0;

    // ---- reset state (request pending must not be accepted) ----
    #2;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_data_addr_ok", data_addr_ok, 0);
    chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    chk("const_len_burst", {arlen, arburst, awlen, awburst}, {8'd0, 2'b01, 8'd0, 2'b01});
    data_req = 0;
    #10 rst = 1'b1;
    tick();

    // ---- single word read on data port ----
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h1FC0_0004;
    #1;
    chk("rd1_addr_ok", data_addr_ok, 1);
    chk("rd1_inst_addr_ok", inst_addr_ok, 0);
    tick();
    data_req = 0;
    chk("rd1_arvalid", arvalid, 1);
    chk("rd1_araddr", araddr, 32'h1FC0_0004);
    chk("rd1_arid", arid, 1);
    chk("rd1_arsize", arsize, 3'b010);
    chk("rd1_addr_ok_busy", data_addr_ok, 0);
    arready = 1;
    tick();
    arready = 0;
    chk("rd1_arvalid_drop", arvalid, 0);
    chk("rd1_rready", rready, 1);
    chk("rd1_no_early_ok", data_data_ok, 0);
    tick();
    chk("rd1_wait_ok", data_data_ok, 0);
    rvalid = 1; rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd1_data_ok", data_data_ok, 1);
    chk("rd1_rdata", data_rdata, 32'hDEAD_BEEF);
    chk("rd1_inst_ok", inst_data_ok, 0);
    tick();
    rvalid = 0;
    chk("rd1_ok_pulse", data_data_ok, 0);
    chk("rd1_rready_drop", rready, 0);

    // ---- byte write at addr[1:0]=2'b10 ----
    data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h0000_1002;
    data_wdata = 32'h00AB_0000;
    #1;
    chk("wr1_addr_ok", data_addr_ok, 1);
    tick();
    data_req = 0;
    chk("wr1_valids", {awvalid, wvalid}, 2'b11);
    chk("wr1_wstrb", wstrb, 4'b0100);
    chk("wr1_awsize", awsize, 3'b000);
    chk("wr1_awaddr", awaddr, 32'h0000_1002);
    chk("wr1_wdata", wdata, 32'h00AB_0000);
    chk("wr1_ids_wlast", {awid, wid, wlast}, {4'd1, 4'd1, 1'b1});
    awready = 1; wready = 1;
    tick();
    awready = 0; wready = 0;
    chk("wr1_valids_drop", {awvalid, wvalid}, 2'b00);
    chk("wr1_bready", bready, 1);
    chk("wr1_no_early_ok", data_data_ok, 0);
    bvalid = 1;
    #1;
    chk("wr1_data_ok", data_data_ok, 1);
    tick();
    bvalid = 0;
    chk("wr1_ok_pulse", data_data_ok, 0);

    // ---- half write, wready 3 cycles before awready ----
    data_req = 1; data_wr = 1; data_size = 1; data_addr = 32'h0000_2002;
    data_wdata = 32'h1234_0000;
    tick();
    data_req = 0;
    chk("wr2_wstrb", wstrb, 4'b1100);
    wready = 1;
    tick();
    wready = 0;
    chk("wr2_w_drop", {awvalid, wvalid}, 2'b10);
    chk("wr2_no_b_1", bready, 0);
    tick();
    chk("wr2_aw_hold_2", {awvalid, wvalid, bready}, 3'b100);
    tick();
    chk("wr2_aw_hold_3", {awvalid, wvalid, bready}, 3'b100);
    awready = 1;
    tick();
    awready = 0;
    chk("wr2_in_b", {awvalid, wvalid, bready}, 3'b001);
    bvalid = 1;
    #1;
    chk("wr2_data_ok", data_data_ok, 1);
    tick();
    bvalid = 0;

    // ---- simultaneous inst and data requests ----
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h0000_3000;
    inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'hBFC0_0000;
    #1;
    chk("arb_data_addr_ok", data_addr_ok, 1);
    chk("arb_inst_addr_ok", inst_addr_ok, 0);
    tick();
    data_req = 0;
    chk("arb_data_arid", arid, 1);
    chk("arb_data_araddr", araddr, 32'h0000_3000);
    chk("arb_inst_wait", inst_addr_ok, 0);
    arready = 1;
    tick();
    arready = 0;
    rvalid = 1; rdata = 32'h0BAD_CAFE;
    #1;
    chk("arb_data_ok", {data_data_ok, inst_data_ok}, 2'b10);
    chk("arb_no_accept_on_ok", inst_addr_ok, 0);
    tick();
    rvalid = 0;
    #1;
    chk("arb_inst_granted", inst_addr_ok, 1);
    tick();
    inst_req = 0;
    chk("arb_inst_arid", arid, 0);
    chk("arb_inst_araddr", araddr, 32'hBFC0_0000);
    arready = 1;
    tick();
    arready = 0;
    rvalid = 1; rdata = 32'h2400_0001;
    #1;
    chk("arb_inst_ok", {inst_data_ok, data_data_ok}, 2'b10);
    chk("arb_inst_rdata", inst_rdata, 32'h2400_0001);
    tick();
    rvalid = 0;

    // ---- reset mid-read ----
    data_req = 1; data_wr = 0; data_addr = 32'h0000_4000;
    tick();
    data_req = 0;
    arready = 1;
    tick();
    arready = 0;
    chk("mid_in_r", rready, 1);
    rst = 0;
    #1;
    chk("mid_rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
    chk("mid_rst_ok", {inst_data_ok, data_data_ok}, 2'b00);
    tick();
    rst = 1;
    rvalid = 1;
    #1;
    chk("mid_no_ok_after", {inst_data_ok, data_data_ok}, 2'b00);
    chk("mid_idle_rready", rready, 0);
    tick();
    rvalid = 0;
`ifdef AXI_BRIDGE_PERF_CNT_EN
    chk("perf_rst", perf_rd_cnt | perf_wr_cnt | perf_wait_cnt, 0);
`endif

    // ---- word write with size 3 (treated as word), proves IDLE after reset ----
    data_req = 1; data_wr = 1; data_size = 3; data_addr = 32'h0000_5001;
    data_wdata = 32'hA5A5_5A5A;
    #1;
    chk("post_rst_addr_ok", data_addr_ok, 1);
    tick();
    data_req = 0;
    chk("wr3_wstrb", wstrb, 4'b1111);
    awready = 1; wready = 1;
    tick();
    awready = 0; wready = 0;
    bvalid = 1;
    #1;
    chk("wr3_data_ok", data_data_ok, 1);
    tick();
    bvalid = 0;

    // ---- two minimal reads (inst then data) ----
    inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'h0000_6000;
    tick();
    inst_req = 0;
    arready = 1;
    tick();
    arready = 0;
    rvalid = 1; rdata = 32'h1111_2222;
    #1;
    chk("rd4_inst_ok", inst_data_ok, 1);
    tick();
    rvalid = 0;
    data_req = 1; data_wr = 0; data_size = 1; data_addr = 32'h0000_7002;
    tick();
    data_req = 0;
    chk("rd5_arsize", arsize, 3'b001);
    arready = 1;
    tick();
    arready = 0;
    rvalid = 1; rdata = 32'h3333_4444;
    #1;
    chk("rd5_data_ok", data_data_ok, 1);
    chk("rd5_rdata", data_rdata, 32'h3333_4444);
    tick();
    rvalid = 0;
`ifdef AXI_BRIDGE_PERF_CNT_EN
    chk("perf_rd", perf_rd_cnt, 2);
    chk("perf_wr", perf_wr_cnt, 1);
    chk("perf_wait", perf_wait_cnt, 6);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
